// File: rtl/register_stream_shifter.sv
`default_nettype none
// ============================================================================
// Module   : register_stream_shifter
// Purpose  : Parallel-in, serial-out word shifter for the pixel readout path.
//            One load captures `length` words of `bits` each. The words stream
//            out lowest index first over a valid/ready handshake. A one-deep
//            shadow buffer accepts the next row while the current row drains,
//            so back-to-back loads stream without a bubble.
// Ports    : clk        - single clock, rising edge
//            reset      - asynchronous, active-low; clears all state
//            clear      - synchronous flush of bank and shadow
//            load       - load request, accepted when load && load_ready
//            data_in    - word i at data_in[i*bits +: bits]
//            load_ready - shadow buffer empty
//            out_valid  - data_out holds a valid word
//            out_ready  - consumer accepts the word
//            data_out   - current word (bank index 0)
//            out_last   - current word is the last of its load
//            remaining  - valid words left in the bank, current one included
// Revision : 1.0 - initial release
// ============================================================================
module register_stream_shifter #(
  parameter int length = 4,
  parameter int bits   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        load,
  input  logic [bits*length-1:0]      data_in,
  output logic                        load_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [bits-1:0]             data_out,
  output logic                        out_last,
  output logic [$clog2(length+1)-1:0] remaining
);

  localparam int                CW      = $clog2(length + 1);
  localparam int                DW      = bits * length;
  localparam logic [CW-1:0]     C_FULL  = CW'(length);
  localparam logic [CW-1:0]     C_ONE   = CW'(1);
  localparam logic [CW-1:0]     C_ZERO  = '0;

  logic [DW-1:0] r_bank;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_shadow;
  logic          r_shadow_full;

  logic w_pop;
  logic w_bank_free;
  logic w_load_acc;

  assign w_pop       = (r_count != C_ZERO) && out_ready;
  // The bank can take new data this cycle if it is empty, or if its last
  // word is leaving right now.
  assign w_bank_free = (r_count == C_ZERO) || ((r_count == C_ONE) && w_pop);
  assign w_load_acc  = load && !r_shadow_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bank        <= '0;
      r_count       <= C_ZERO;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
    end else if (clear) begin
      r_bank        <= '0;
      r_count       <= C_ZERO;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
    end else if (w_bank_free && r_shadow_full) begin
      // Pending row moves in; load_ready is low so no load can collide.
      r_bank        <= r_shadow;
      r_count       <= C_FULL;
      r_shadow_full <= 1'b0;
    end else if (w_bank_free && w_load_acc) begin
      r_bank        <= data_in;
      r_count       <= C_FULL;
    end else begin
      if (w_pop) begin
        // Zero-fill the vacated top word so drained banks read as zero.
        r_bank  <= {{bits{1'b0}}, r_bank[DW-1:bits]};
        r_count <= r_count - C_ONE;
      end
      if (w_load_acc) begin
        r_shadow      <= data_in;
        r_shadow_full <= 1'b1;
      end
    end
  end

  assign load_ready = !r_shadow_full;
  assign out_valid  = (r_count != C_ZERO);
  assign out_last   = (r_count == C_ONE);
  assign data_out   = r_bank[bits-1:0];
  assign remaining  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_register_stream_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_register_stream_shifter
// Purpose  : Self-checking bench for register_stream_shifter. A queue-based
//            model tracks bank contents and the pending shadow row; every
//            cycle the DUT outputs are compared against it. Directed
//            sequences add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_stream_shifter;

  localparam int L  = 4;
  localparam int B  = 4;
  localparam int CW = $clog2(L + 1);

  logic           clk = 1'b0;
  logic           reset;
  logic           clear;
  logic           load;
  logic [L*B-1:0] data_in;
  logic           load_ready;
  logic           out_valid;
  logic           out_ready;
  logic [B-1:0]   data_out;
  logic           out_last;
  logic [CW-1:0]  remaining;

  int total = 0;
  int bad   = 0;

  // Model: words still in the bank (front = current) and the pending row.
  logic [B-1:0] mq[$];
  logic [B-1:0] msh[$];

  register_stream_shifter #(.length(L), .bits(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .load      (load),
    .data_in   (data_in),
    .load_ready(load_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_last  (out_last),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    msh.delete();
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic pop, free, acc;
    logic [B-1:0] w[$];
    if (clear) begin
      model_clear();
      return;
    end
    for (int i = 0; i < L; i++) w.push_back(data_in[i*B +: B]);
    pop  = (mq.size() != 0) && out_ready;
    free = (mq.size() == 0) || ((mq.size() == 1) && pop);
    acc  = load && (msh.size() == 0);
    if (pop) void'(mq.pop_front());
    if (free && msh.size() != 0) begin
      mq = msh;
      msh.delete();
    end else if (free && acc) begin
      mq = w;
    end else if (acc) begin
      msh = w;
    end
  endtask

  task automatic compare_all();
    chk("out_valid",  32'(out_valid),  32'(mq.size() != 0));
    chk("out_last",   32'(out_last),   32'(mq.size() == 1));
    chk("remaining",  32'(remaining),  32'(mq.size()));
    chk("load_ready", 32'(load_ready), 32'(msh.size() == 0));
    chk("data_out",   32'(data_out),   (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  logic [B-1:0] exp_seq [8];

  initial begin
    reset = 1'b0; clear = 1'b0; load = 1'b0; out_ready = 1'b0; data_in = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset state and idle load
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_remaining",  32'(remaining),  32'd0);
    out_ready = 1'b1; load = 1'b1; data_in = 16'h4321;
    step();
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("idle_word", 32'(data_out), 32'(k));
      chk("idle_last", 32'(out_last), 32'(k == 4));
      step();
    end
    chk("idle_drained", 32'(out_valid), 32'd0);

    // Back-to-back loads with a blocked load while the shadow is full
    exp_seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
    load = 1'b1; data_in = 16'h4321;
    step();
    for (int k = 0; k < 8; k++) begin
      chk("b2b_word", 32'(data_out), 32'(exp_seq[k]));
      if (k == 1) chk("b2b_shadow_full", 32'(load_ready), 32'd0);
      if (k == 4) chk("b2b_ready_back",  32'(load_ready), 32'd1);
      if (k == 0) begin load = 1'b1; data_in = 16'hDCBA; end
      else if (k == 2) begin load = 1'b1; data_in = 16'hFFFF; end
      else load = 1'b0;
      step();
    end
    chk("b2b_drained", 32'(out_valid), 32'd0);

    // Backpressure at word 2
    load = 1'b1; data_in = 16'h4321;
    step();
    load = 1'b0;
    step();
    out_ready = 1'b0;
    repeat (3) begin
      step();
      chk("bp_hold_data", 32'(data_out),  32'd2);
      chk("bp_hold_rem",  32'(remaining), 32'd3);
    end
    out_ready = 1'b1;
    step();
    chk("bp_resume", 32'(data_out), 32'd3);
    repeat (3) step();

    // Clear with simultaneous load and pop
    load = 1'b1; data_in = 16'h4321;
    step();
    load = 1'b1; data_in = 16'h8765; clear = 1'b1;
    step();
    clear = 1'b0; load = 1'b0;
    chk("clr_rem",   32'(remaining),  32'd0);
    chk("clr_valid", 32'(out_valid),  32'd0);
    chk("clr_ready", 32'(load_ready), 32'd1);
    step();
    chk("clr_discard", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream
    load = 1'b1; data_in = 16'h4321;
    step();
    load = 1'b0;
    repeat (2) step();
    chk("ar_pre_rem", 32'(remaining), 32'd2);
    #2 reset = 1'b0;
    #1;
    model_clear();
    chk("ar_rem",   32'(remaining),  32'd0);
    chk("ar_valid", 32'(out_valid),  32'd0);
    chk("ar_last",  32'(out_last),   32'd0);
    chk("ar_data",  32'(data_out),   32'd0);
    chk("ar_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    load = 1'b1; data_in = 16'h4321;
    step();
    load = 1'b0;
    chk("ar_fresh_first", 32'(data_out), 32'd1);
    repeat (4) step();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      clear     = ($urandom_range(0, 29) == 0);
      load      = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 3) != 0);
      data_in   = 16'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_stream_shifter.md
# register_stream_shifter

Parallel-in, serial-out word shifter for the pixel readout path. Captures `length` words of `bits` each in one load, then streams them out lowest index first over a valid/ready handshake. A one-deep shadow buffer lets the next frame row load while the current one drains, so back-to-back loads stream with no bubble. Clocked, synchronous successor to the set-strobed shifter. It sits between the ADC result registers and the serial readout bus.

## Interface
Parameters:
- `length`, 4, words per load (≥2)
- `bits`, 4, width of one word (≥1)

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low; asserting clears all state immediately
- `clear`  in  1  synchronous flush of bank and shadow, active-high
- `load`  in  1  load request; accepted when `load && load_ready`
- `data_in`  in  bits*length  word i at `data_in[i*bits +: bits]`
- `load_ready`  out  1  shadow buffer empty; depends on registered state only
- `out_valid`  out  1  `data_out` holds a valid word
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`
- `data_out`  out  bits  current word, bank index 0
- `out_last`  out  1  current word is the last of its load
- `remaining`  out  $clog2(length+1)  valid words left in the bank, including the current one

## Operation
- Storage: shift bank of `length` words with a word count, plus a shadow holding `length` words and a full flag.
- Reset values (`reset` low): bank, shadow and `data_out` = 0; `remaining` = 0; `out_valid` = 0; `out_last` = 0; shadow empty; `load_ready` = 1.
- `out_valid` = (`remaining` != 0). `out_last` = (`remaining` == 1). `load_ready` = !shadow_full.
- A pop is `out_valid && out_ready`. On a pop, bank word i ← word i+1, top word ← 0 (never X), and `remaining` decrements.
- A bank is "free" this cycle when `remaining` == 0, or when `remaining` == 1 and a pop occurs.
- An accepted load goes directly into the bank when the bank is free and the shadow is empty. `remaining` ← `length`.
- Otherwise an accepted load goes into the shadow, and shadow_full ← 1.
- Whenever the bank is free and the shadow is full, the shadow moves into the bank, `remaining` ← `length`, and the shadow empties.
- A load in the same cycle as that transfer is impossible, because `load_ready` is 0 while the shadow is full.
- `load` while `load_ready` = 0 is ignored. `data_in` is sampled only on acceptance.
- `clear` resets bank, shadow and `remaining` to their reset values on the next edge. `clear` has priority over a simultaneous load and a simultaneous pop; both are discarded.
- `reset` asserted mid-stream aborts immediately. After release the block behaves as freshly reset; no partial words survive.

## Timing
- Load-to-output latency: a load accepted at edge N into an idle block gives `out_valid` = 1 and `data_out` = word 0 after edge N.
- Throughput: one word per cycle while `out_ready` = 1. With the shadow pre-filled, the word after a `out_last` pop is word 0 of the next load, on the next cycle with no idle cycle.
- Backpressure: while `out_ready` = 0, `data_out`, `out_last` and `remaining` hold stable.
- `remaining` never exceeds `length` and never wraps below 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Test plan
- **Reset and idle load** (`length`=4, `bits`=4): after reset, check `load_ready`=1, `out_valid`=0 and `remaining`=0. Load `data_in`=16'h4321 with `out_ready`=1. Required response: `data_out` = 1, 2, 3, 4 on consecutive cycles, `out_last` high only with 4, then `out_valid`=0.
- **Back-to-back loads:** load 16'h4321, then load 16'hDCBA the next cycle while streaming. Required response: shadow fills and `load_ready`=0. Output is 1, 2, 3, 4, A, B, C, D with no gap. `load_ready` returns to 1 on the cycle after the transfer.
- **Backpressure:** during the stream, hold `out_ready`=0 for 3 cycles at word 2. Required response: `data_out`=2 and `remaining`=3 are held throughout, and the stream resumes with 3.
- **Blocked load:** with the shadow full, pulse `load` with 16'hFFFF. Required response: the load is ignored and 16'hFFFF never appears on `data_out`.
- **Clear:** assert `clear` together with `load` and a pop. Required response: next cycle `remaining`=0, `out_valid`=0, `load_ready`=1, and the new data is discarded.
- **Asynchronous reset mid-stream:** drive `reset` low between clock edges with `remaining`=2. Required response: outputs reach their reset values before the next edge, and a fresh load after release streams correctly.
